// File: rtl/huffman_decoder_if.sv
// -----------------------------------------------------------------------------
// huffman_decoder_if
// Bundles every non-clock/reset signal of huffman_decoder.
//
// Handshake rules, used by both streams:
//   A transfer happens on a rising CLK edge where both VALID and READY are 1.
//   A source holding VALID must keep its data stable until the transfer. VALID
//   must never wait for READY. READY may depend on state, not on VALID.
//   - bit stream    : BIT_VALID / BIT_READY, data BIT_IN   (source -> decoder)
//   - symbol stream : SYM_VALID / SYM_READY, data SYM_OUT  (decoder -> sink)
//
// Signals:
//   TABLE_WE/SYM/LEN/CODE : code table write port (taken only in IDLE)
//   START, SYM_TOTAL      : run start pulse and number of symbols to decode
//   BIT_IN/VALID/READY    : serial code bit stream, MSB of each code first
//   SYM_OUT/VALID/READY   : decoded 4-bit characters
//   DONE                  : one-cycle pulse after the last symbol is taken
//   ERR                   : sticky invalid-code flag
//   STATE_DBG             : current FSM state (debug/observability)
// Modports: master = stimulus/system side, slave = decoder side.
// -----------------------------------------------------------------------------
interface huffman_decoder_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
);
    logic               TABLE_WE;
    logic [3:0]         TABLE_SYM;
    logic [3:0]         TABLE_LEN;
    logic [MAX_LEN-1:0] TABLE_CODE;
    logic               START;
    logic [CNT_W-1:0]   SYM_TOTAL;
    logic               BIT_IN;
    logic               BIT_VALID;
    logic               BIT_READY;
    logic [3:0]         SYM_OUT;
    logic               SYM_VALID;
    logic               SYM_READY;
    logic               DONE;
    logic               ERR;
    logic [1:0]         STATE_DBG;

    modport master (
        output TABLE_WE, TABLE_SYM, TABLE_LEN, TABLE_CODE,
        output START, SYM_TOTAL,
        output BIT_IN, BIT_VALID,
        input  BIT_READY,
        input  SYM_OUT, SYM_VALID,
        output SYM_READY,
        input  DONE, ERR, STATE_DBG
    );

    modport slave (
        input  TABLE_WE, TABLE_SYM, TABLE_LEN, TABLE_CODE,
        input  START, SYM_TOTAL,
        input  BIT_IN, BIT_VALID,
        output BIT_READY,
        output SYM_OUT, SYM_VALID,
        input  SYM_READY,
        output DONE, ERR, STATE_DBG
    );
endinterface

// File: rtl/huffman_decoder.sv
// -----------------------------------------------------------------------------
// huffman_decoder
// Serial Huffman decoder for the 4-bit character alphabet. Code bits arrive
// MSB-first, one per bit handshake; each completed code is looked up against a
// 16-entry {len, code} table and the matching character is emitted on the
// symbol handshake. A run decodes SYM_TOTAL symbols and ends with a DONE pulse.
//
// Ports:
//   CLK   : system clock, all state on the rising edge
//   nRST  : asynchronous active-low reset
//   bus   : huffman_decoder_if.slave (table port, START/SYM_TOTAL, bit stream,
//           symbol stream, DONE, ERR, STATE_DBG)
// -----------------------------------------------------------------------------
module huffman_decoder #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    huffman_decoder_if.slave bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_OUTPUT = 2'd2;
    localparam logic [1:0] S_ERROR  = 2'd3;

    localparam logic [3:0] LEN_LIMIT = 4'(MAX_LEN);

    logic [1:0]         state;
    logic [MAX_LEN-1:0] acc;
    logic [3:0]         len;
    logic [CNT_W-1:0]   remaining;
    logic [3:0]         sym_out;
    logic               sym_valid;
    logic               done;
    logic               err;

    logic [3:0]         tbl_len  [16];
    logic [MAX_LEN-1:0] tbl_code [16];

    logic [MAX_LEN-1:0] next_acc;
    logic [3:0]         next_len;
    logic [MAX_LEN-1:0] len_mask;
    logic               hit;
    logic [3:0]         hit_sym;
    logic               start_ok;

    // Candidate code after taking the current bit, and the parallel table
    // lookup. The loop runs from the top index down so that, for a table that
    // is not prefix-free, the lowest matching symbol index is the one kept.
    always_comb begin
        next_acc = {acc[MAX_LEN-2:0], bus.BIT_IN};
        next_len = len + 4'd1;
        len_mask = '0;
        for (int b = 0; b < MAX_LEN; b++) begin
            len_mask[b] = (4'(b) < next_len);
        end
        hit     = 1'b0;
        hit_sym = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if ((tbl_len[i] == next_len) &&
                (((tbl_code[i] ^ next_acc) & len_mask) == '0)) begin
                hit     = 1'b1;
                hit_sym = 4'(i);
            end
        end
    end

    // ERROR accepts START exactly like IDLE; START elsewhere is ignored.
    assign start_ok = bus.START && ((state == S_IDLE) || (state == S_ERROR));

    // Code table: written only while idle, lengths cleared by reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 16; i++) begin
                tbl_len[i]  <= 4'd0;
                tbl_code[i] <= '0;
            end
        end else if (bus.TABLE_WE && (state == S_IDLE)) begin
            tbl_len[bus.TABLE_SYM]  <= bus.TABLE_LEN;
            tbl_code[bus.TABLE_SYM] <= bus.TABLE_CODE;
        end
    end

    // Main FSM.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= S_IDLE;
            acc       <= '0;
            len       <= 4'd0;
            remaining <= '0;
            sym_out   <= 4'd0;
            sym_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_ERROR: begin
                    if (start_ok) begin
                        err <= 1'b0;
                        acc <= '0;
                        len <= 4'd0;
                        if (bus.SYM_TOTAL != '0) begin
                            remaining <= bus.SYM_TOTAL;
                            state     <= S_DECODE;
                        end else begin
                            // Empty run: finish immediately.
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end

                S_DECODE: begin
                    if (bus.BIT_VALID) begin
                        if (hit) begin
                            sym_out   <= hit_sym;
                            sym_valid <= 1'b1;
                            acc       <= '0;
                            len       <= 4'd0;
                            state     <= S_OUTPUT;
                        end else if (next_len == LEN_LIMIT) begin
                            // A full-length code with no match cannot belong
                            // to any table entry.
                            err   <= 1'b1;
                            acc   <= '0;
                            len   <= 4'd0;
                            state <= S_ERROR;
                        end else begin
                            acc <= next_acc;
                            len <= next_len;
                        end
                    end
                end

                S_OUTPUT: begin
                    if (bus.SYM_READY) begin
                        sym_valid <= 1'b0;
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            state <= S_DECODE;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.BIT_READY = (state == S_DECODE);
    assign bus.SYM_OUT   = sym_out;
    assign bus.SYM_VALID = sym_valid;
    assign bus.DONE      = done;
    assign bus.ERR       = err;
    assign bus.STATE_DBG = state;

endmodule

// File: doc/huffman_decoder.md
# huffman_decoder

Serial Huffman decoder for the 4-bit (nibble) character alphabet used by the compression path. It consumes the MSB-first code bitstream produced by the encoder and emits the original 4-bit characters one per handshake. The code table (length + code per symbol, built from `count_frequent` statistics) is loaded over a write port before each run. It sits at the receive end of the Huffman link and restores the character stream that fed `count_frequent`.

## Interface
- `MAX_LEN`, 8, maximum code length in bits (2..15); sets width of codes and length-counter overflow point
- `CNT_W`, 16, width of the symbol-count input
- `CLK`  in  1  system clock, all state on rising edge
- `nRST`  in  1  asynchronous active-low reset
- `TABLE_WE`  in  1  table write strobe; honoured only in IDLE
- `TABLE_SYM`  in  4  symbol index being written
- `TABLE_LEN`  in  4  code length; 0 = symbol unused
- `TABLE_CODE`  in  MAX_LEN  code, right-aligned, first transmitted bit is bit `TABLE_LEN-1`
- `START`  in  1  one-cycle pulse; begins a run (honoured in IDLE and ERROR)
- `SYM_TOTAL`  in  CNT_W  number of symbols to decode, sampled with START
- `BIT_IN`  in  1  code bit
- `BIT_VALID`  in  1  BIT_IN valid
- `BIT_READY`  out  1  decoder accepts a bit this cycle
- `SYM_OUT`  out  4  decoded character
- `SYM_VALID`  out  1  SYM_OUT valid
- `SYM_READY`  in  1  downstream accepts SYM_OUT
- `DONE`  out  1  one-cycle pulse after last symbol handed off
- `ERR`  out  1  invalid code detected; sticky

## Operation
- States: IDLE, DECODE, OUTPUT, ERROR.
- Table: 16 entries of {len[3:0], code[MAX_LEN-1:0]}; write in IDLE on `TABLE_WE` at clock edge; writes in other states ignored. Table persists across runs; reset clears all lens to 0.
- IDLE: START with SYM_TOTAL≠0 -> load remaining=SYM_TOTAL, clear acc/len, -> DECODE. START with SYM_TOTAL=0 -> DONE pulse next cycle, stay IDLE.
- DECODE: `BIT_READY`=1. On BIT_VALID&&BIT_READY: next_acc={acc,BIT_IN} (MAX_LEN bits), next_len=len+1. Combinationally compare all 16 entries: match when entry.len==next_len and entry.code==next_acc (low next_len bits). Multiple matches (non-prefix-free table): lowest symbol index wins.
  - match -> register SYM_OUT, SYM_VALID=1, clear acc/len, -> OUTPUT.
  - no match and next_len==MAX_LEN -> ERR=1, -> ERROR.
  - else store acc/len, stay.
- OUTPUT: `BIT_READY`=0, SYM_VALID held with SYM_OUT stable until SYM_READY. On handshake: SYM_VALID=0, remaining-=1; if remaining was 1 -> DONE=1 for one cycle, -> IDLE; else -> DECODE.
- ERROR: BIT_READY=0, SYM_VALID=0, ERR=1 held. START -> clears ERR, behaves as START in IDLE. Table writes ignored.
- START in DECODE/OUTPUT ignored. Excess bits after final symbol are not consumed (BIT_READY=0 in IDLE).

## Timing
- Reset values: state IDLE, BIT_READY=0, SYM_OUT=0, SYM_VALID=0, DONE=0, ERR=0, remaining=0, acc=0, len=0, all table lens=0. Reset mid-run aborts immediately; no partial symbol emitted.
- START at edge t -> BIT_READY=1 from cycle t+1.
- Last code bit accepted at edge t -> SYM_VALID=1 in cycle t+1 (latency 1).
- SYM_READY high in cycle t+1 -> DECODE again cycle t+2; sustained rate = code length + 1 cycles per symbol.
- Final handshake at edge t -> DONE=1 in cycle t+1 only, state IDLE.
- Error: offending bit accepted at edge t -> ERR=1, BIT_READY=0 from cycle t+1.
- BIT_VALID while BIT_READY=0: bit not consumed; source must hold it.

## Test plan
- Load A=`0`(len1), B=`10`(2), D=`110`(3), C=`111`(3); START, SYM_TOTAL=7; stream 0,0,111,110,110,10,10 (15 bits, BIT_VALID and SYM_READY always 1) -> SYM_OUT sequence A,A,C,D,D,B,B; DONE one cycle after 7th handshake; ERR=0; exactly 22 cycles from first BIT_READY to DONE.
- Same stream, SYM_READY low for 5 cycles on 3rd symbol -> SYM_OUT=C held stable 6 cycles, BIT_READY=0 throughout, output sequence unchanged.
- MAX_LEN=8, table only A=`0`; send eight 1s -> ERR=1 after 8th bit, BIT_READY=0; START with SYM_TOTAL=1 and bit 0 -> ERR clears, SYM_OUT=A, DONE.
- START with SYM_TOTAL=0 -> DONE pulse next cycle, no BIT_READY, no SYM_VALID.
- Table write during DECODE (A->len2) ignored: decoding `0` still yields A; nRST low mid-symbol (after 2 of 3 bits) -> all outputs 0, table lens 0, state IDLE.
- Non-prefix-free table: sym 3 and sym 9 both `01` -> input 0,1 yields SYM_OUT=3.
